alu_uart_interface: RTL
=======================

Name: alu_uart_interface

Overview:
- Front-end that drives the ALU from a serial link instead of board switches/buttons.
- Consumes received bytes (rx_data/rx_done strobe) in the order operand A, operand B, opcode, and drives the ALU operand/opcode inputs.
- Samples the ALU result and hands it to the UART transmitter (tx_start/tx_done handshake).
- Sits between uart_rx/uart_tx and ALU; it is the initiator for which the ALU is the responder.

Parameters:
DATA_W, 8, width of operands, result and serial bytes
OP_W, 6, opcode width; taken from rx_data[OP_W-1:0], upper bits ignored

Ports:
mclk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
rx_data  input  DATA_W  byte from uart_rx, valid only while rx_done=1
rx_done  input  1  one-cycle strobe: rx_data holds a new byte
alu_result  input  DATA_W  ALU output W (combinational from alu_a/alu_b/alu_op)
tx_done  input  1  one-cycle strobe from uart_tx: byte fully sent
alu_a  output  DATA_W  registered operand A to ALU
alu_b  output  DATA_W  registered operand B to ALU
alu_op  output  OP_W  registered opcode to ALU
tx_data  output  DATA_W  byte to uart_tx, held stable from tx_start until tx_done
tx_start  output  1  one-cycle pulse requesting transmission
busy  output  1  high in states EVAL, SEND, WAIT_TX
drop_err  output  1  sticky: a byte arrived while busy and was discarded

Behaviour:
- Reset (async, any time incl. mid-transmission): state=GET_A; alu_a, alu_b, alu_op, tx_data = 0; tx_start, busy, drop_err = 0. A reset between bytes discards the partial triplet.
- FSM states: GET_A, GET_B, GET_OP, EVAL, SEND, WAIT_TX.
- GET_A: on rx_done, alu_a <= rx_data, go to GET_B. Without rx_done, hold.
- GET_B: on rx_done, alu_b <= rx_data, go to GET_OP.
- GET_OP: on rx_done, alu_op <= rx_data[OP_W-1:0], go to EVAL.
- EVAL: one cycle with no handshake. tx_data <= alu_result, where alu_result reflects the operands registered in earlier cycles. Go to SEND.
- SEND: tx_start=1 for exactly this cycle. Go to WAIT_TX.
- WAIT_TX: tx_start=0. On tx_done, go to GET_A. tx_data is held.
- Latency: the rx_done edge of the opcode byte is followed by the EVAL edge (+1), then tx_start is high during the next cycle (+2).
- tx_done arriving in any state other than WAIT_TX is ignored.
- rx_done in EVAL, SEND or WAIT_TX: the byte is dropped, drop_err <= 1, and the state is unaffected. drop_err clears only on reset.
- alu_a, alu_b and alu_op keep their last values after the result is sent, until overwritten by the next triplet.
- rx_done held high for multiple cycles is treated as one byte per cycle high; the source guarantees single-cycle strobes.
- No arithmetic is done in this block; widths pass straight through. Opcode upper bits are truncated.

Test Plan:
- Reset, then send bytes 0x05, 0x03, 0x20 (ADD) with rx_done strobes 10 cycles apart -> alu_a=0x05, alu_b=0x03, alu_op=6'h20; tx_start pulses exactly 2 cycles after the 3rd strobe; tx_data=0x08 (ALU returns 0x08); tx_data stable until tx_done.
- Back-to-back triplets: 0xFF, 0x01, 0x20, then tx_done, then 0x0F, 0xF0, 0x25 (OR) -> first tx_data=0x00 (wrap), second tx_data=0xFF; busy low between triplets.
- Byte 0x77 strobed during WAIT_TX -> drop_err=1; alu_a unchanged; after tx_done the next byte 0x11 loads alu_a=0x11.
- Assert reset after 2 bytes (0xAA, 0x55) -> all outputs 0 and state GET_A immediately (asynchronous); next bytes 0x01, 0x02, 0x20 give tx_data=0x03.
- Assert reset during WAIT_TX -> tx_start never re-pulses; a tx_done arriving after reset release is ignored.
- Opcode byte 0xE2 -> alu_op=6'h22; spurious tx_done in GET_B -> no state change.

Source files
------------

// File: rtl/alu_uart_interface_if.sv
// Bus between the serial front-end and its surroundings: received bytes in,
// ALU operands/opcode out, result byte handed to the UART transmitter.
interface alu_uart_interface_if #(
    parameter int DATA_W = 8,
    parameter int OP_W   = 6
);
    logic [DATA_W-1:0] rx_data;
    logic              rx_done;
    logic [DATA_W-1:0] alu_result;
    logic              tx_done;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [OP_W-1:0]   alu_op;
    logic [DATA_W-1:0] tx_data;
    logic              tx_start;
    logic              busy;
    logic              drop_err;

    modport master (
        input  rx_data, rx_done, alu_result, tx_done,
        output alu_a, alu_b, alu_op, tx_data, tx_start, busy, drop_err
    );

    modport slave (
        output rx_data, rx_done, alu_result, tx_done,
        input  alu_a, alu_b, alu_op, tx_data, tx_start, busy, drop_err
    );
endinterface

// File: rtl/alu_uart_interface.sv
// Serial front-end for the ALU: collects A, B, opcode bytes from uart_rx,
// latches the ALU result and hands it to uart_tx with a start/done handshake.
module alu_uart_interface #(
    parameter int DATA_W = 8,
    parameter int OP_W   = 6
) (
    input  logic                  mclk,
    input  logic                  reset,
    alu_uart_interface_if.master  bus
);
    localparam logic [2:0] GET_A   = 3'd0;
    localparam logic [2:0] GET_B   = 3'd1;
    localparam logic [2:0] GET_OP  = 3'd2;
    localparam logic [2:0] EVAL    = 3'd3;
    localparam logic [2:0] SEND    = 3'd4;
    localparam logic [2:0] WAIT_TX = 3'd5;

    logic [2:0]        state;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [OP_W-1:0]   op_q;
    logic [DATA_W-1:0] tx_q;
    logic              drop_q;

    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            state  <= GET_A;
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= '0;
            tx_q   <= '0;
            drop_q <= 1'b0;
        end else begin
            case (state)
                GET_A: if (bus.rx_done) begin
                    a_q   <= bus.rx_data;
                    state <= GET_B;
                end
                GET_B: if (bus.rx_done) begin
                    b_q   <= bus.rx_data;
                    state <= GET_OP;
                end
                GET_OP: if (bus.rx_done) begin
                    op_q  <= bus.rx_data[OP_W-1:0];
                    state <= EVAL;
                end
                // Operands have been stable for a full cycle, so the ALU output is settled.
                EVAL: begin
                    tx_q  <= bus.alu_result;
                    state <= SEND;
                end
                SEND:    state <= WAIT_TX;
                WAIT_TX: if (bus.tx_done) state <= GET_A;
                default: state <= GET_A;
            endcase

            if (bus.rx_done && (state == EVAL || state == SEND || state == WAIT_TX))
                drop_q <= 1'b1;
        end
    end

    assign bus.alu_a    = a_q;
    assign bus.alu_b    = b_q;
    assign bus.alu_op   = op_q;
    assign bus.tx_data  = tx_q;
    assign bus.tx_start = (state == SEND);
    assign bus.busy     = (state == EVAL) || (state == SEND) || (state == WAIT_TX);
    assign bus.drop_err = drop_q;
endmodule
